// File: rtl/cam_cfg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cam_cfg_seq
// Purpose : Camera register-init sequencer. Walks a synchronous ROM of
//           {reg_addr[15:0], reg_data[7:0]} entries and issues one 24-bit
//           SCCB/I2C write per entry, with NACK retry, delay markers
//           (reg_addr 16'hFFFE) and an end marker (reg_addr 16'hFFFF).
// Options : CAM_CFG_TIMEOUT_EN - per-write watchdog over WAIT_DONE+RELEASE.
// Revision: 1.0 - initial release
// ============================================================================
module cam_cfg_seq #(
    parameter int          NUM_REGS    = 256,
    parameter int          MAX_RETRY   = 3,
    parameter int          DELAY_UNIT  = 25000,
    parameter logic [19:0] TIMEOUT_CYC = 20'd800000
) (
    input  logic                          meg25,
    input  logic                          reset,
    input  logic                          start,
    output logic [$clog2(NUM_REGS)-1:0]   rom_addr,
    input  logic [23:0]                   rom_data,
    output logic [23:0]                   send_dat,
    output logic                          sendit,
    input  logic                          i2c_done,
    input  logic                          i2c_ack,
    output logic                          i2c_reset,
    output logic                          busy,
    output logic                          cfg_done,
    output logic                          cfg_err,
    output logic [$clog2(NUM_REGS)-1:0]   err_index
);

    localparam int C_AW = $clog2(NUM_REGS);
    localparam int C_RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int C_UW = $clog2(DELAY_UNIT + 1);

    localparam logic [C_AW-1:0] C_LAST_ADDR = C_AW'(NUM_REGS - 1);
    localparam logic [C_RW-1:0] C_MAX_RETRY = C_RW'(MAX_RETRY);
    localparam logic [C_UW-1:0] C_UNIT_LAST = C_UW'(DELAY_UNIT - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_SEND      = 4'd3;
    localparam logic [3:0] S_WAIT_DONE = 4'd4;
    localparam logic [3:0] S_RELEASE   = 4'd5;
    localparam logic [3:0] S_DELAY     = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    logic [3:0]      state_q,     state_d;
    logic [C_AW-1:0] rom_addr_q,  rom_addr_d;
    logic [23:0]     send_dat_q,  send_dat_d;
    logic            sendit_q,    sendit_d;
    logic            i2c_reset_q, i2c_reset_d;
    logic            busy_q,      busy_d;
    logic            cfg_done_q,  cfg_done_d;
    logic            cfg_err_q,   cfg_err_d;
    logic [C_AW-1:0] err_index_q, err_index_d;
    logic [C_RW-1:0] retry_q,     retry_d;
    logic            ack_q,       ack_d;
    logic [7:0]      dly_ticks_q, dly_ticks_d;
    logic [C_UW-1:0] unit_q,      unit_d;

    logic [15:0]     w_reg_addr;
    logic [7:0]      w_reg_data;
    logic            w_advance;

    assign w_reg_addr = rom_data[23:8];
    assign w_reg_data = rom_data[7:0];

`ifdef CAM_CFG_TIMEOUT_EN
    logic [19:0]     wd_q, wd_d;
`else
    // Watchdog limit is only meaningful when the watchdog is built in.
    localparam logic [19:0] C_UNUSED_TIMEOUT = TIMEOUT_CYC;
`endif

    // Next-state logic: sequencing, retry decisions, delay timing and watchdog.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        send_dat_d  = send_dat_q;
        sendit_d    = sendit_q;
        i2c_reset_d = 1'b0;
        busy_d      = busy_q;
        cfg_done_d  = cfg_done_q;
        cfg_err_d   = cfg_err_q;
        err_index_d = err_index_q;
        retry_d     = retry_q;
        ack_d       = ack_q;
        dly_ticks_d = dly_ticks_q;
        unit_d      = unit_q;
        w_advance   = 1'b0;

        case (state_q)
            // DONE and ERROR are resting states; start re-runs from entry 0.
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    cfg_done_d = 1'b0;
                    cfg_err_d  = 1'b0;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (w_reg_addr == 16'hFFFF) begin
                    busy_d     = 1'b0;
                    cfg_done_d = 1'b1;
                    state_d    = S_DONE;
                end else if (w_reg_addr == 16'hFFFE) begin
                    if (w_reg_data == 8'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        dly_ticks_d = w_reg_data;
                        unit_d      = '0;
                        state_d     = S_DELAY;
                    end
                end else begin
                    send_dat_d  = rom_data;
                    i2c_reset_d = 1'b1;
                    retry_d     = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                sendit_d = 1'b1;
                state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i2c_done) begin
                    ack_d    = i2c_ack;
                    sendit_d = 1'b0;
                    state_d  = S_RELEASE;
                end
            end
            // Holding here until done clears guarantees a sendit-low gap.
            S_RELEASE: begin
                if (!i2c_done) begin
                    if (!ack_q) begin
                        w_advance = 1'b1;
                    end else if (retry_q < C_MAX_RETRY) begin
                        retry_d     = retry_q + 1'b1;
                        i2c_reset_d = 1'b1;
                        state_d     = S_SEND;
                    end else begin
                        err_index_d = rom_addr_q;
                        busy_d      = 1'b0;
                        cfg_err_d   = 1'b1;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (unit_q == C_UNIT_LAST) begin
                    unit_d = '0;
                    if (dly_ticks_q == 8'd1) begin
                        w_advance = 1'b1;
                    end else begin
                        dly_ticks_d = dly_ticks_q - 8'd1;
                    end
                end else begin
                    unit_d = unit_q + 1'b1;
                end
            end
            default: begin
                sendit_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // The last ROM slot ends the sequence instead of wrapping to entry 0.
        if (w_advance) begin
            if (rom_addr_q == C_LAST_ADDR) begin
                busy_d     = 1'b0;
                cfg_done_d = 1'b1;
                state_d    = S_DONE;
            end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = S_FETCH;
            end
        end

`ifdef CAM_CFG_TIMEOUT_EN
        wd_d = wd_q;
        if (state_q == S_SEND) begin
            wd_d = '0;
        end else if ((state_q == S_WAIT_DONE) || (state_q == S_RELEASE)) begin
            if (wd_q == (TIMEOUT_CYC - 20'd1)) begin
                // A stuck writer is fatal: no retry, overrides any other outcome.
                sendit_d    = 1'b0;
                i2c_reset_d = 1'b0;
                rom_addr_d  = rom_addr_q;
                err_index_d = rom_addr_q;
                busy_d      = 1'b0;
                cfg_done_d  = cfg_done_q;
                cfg_err_d   = 1'b1;
                state_d     = S_ERROR;
            end else begin
                wd_d = wd_q + 20'd1;
            end
        end
`endif
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge meg25) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            send_dat_q  <= '0;
            sendit_q    <= 1'b0;
            i2c_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_index_q <= '0;
            retry_q     <= '0;
            ack_q       <= 1'b0;
            dly_ticks_q <= '0;
            unit_q      <= '0;
`ifdef CAM_CFG_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            send_dat_q  <= send_dat_d;
            sendit_q    <= sendit_d;
            i2c_reset_q <= i2c_reset_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            err_index_q <= err_index_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            dly_ticks_q <= dly_ticks_d;
            unit_q      <= unit_d;
`ifdef CAM_CFG_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign send_dat  = send_dat_q;
    assign sendit    = sendit_q;
    assign i2c_reset = i2c_reset_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign err_index = err_index_q;

endmodule
`default_nettype wire
